// File: rtl/step_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : step_sequencer_if
// Brief    : Control/status bundle between the tempo/UI side (master) and
//            the step sequencer core (slave).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface step_sequencer_if #(
    parameter int NUM_TRACKS = 5,
    parameter int NUM_STEPS  = 16
) ();
    localparam int SW = $clog2(NUM_STEPS);

    logic                            CCEN;
    logic                            Start;
    logic                            Stop;
    logic                            Clear;
    logic [NUM_TRACKS-1:0]           Toggle;
    logic [SW-1:0]                   EditStep;
    logic [SW:0]                     LoopLen;
    logic [SW-1:0]                   Step;
    logic                            Playing;
    logic [NUM_TRACKS-1:0]           TrigOut;
    logic                            Wrap;
    logic [NUM_TRACKS*NUM_STEPS-1:0] Pattern;

    modport master (
        output CCEN, Start, Stop, Clear, Toggle, EditStep, LoopLen,
        input  Step, Playing, TrigOut, Wrap, Pattern
    );

    modport slave (
        input  CCEN, Start, Stop, Clear, Toggle, EditStep, LoopLen,
        output Step, Playing, TrigOut, Wrap, Pattern
    );
endinterface
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : step_sequencer
// Brief    : Multi-track looping step sequencer. One NUM_STEPS-bit pattern per
//            track, step pointer advanced on CCEN ticks, programmable loop
//            length, live toggles in PLAY and addressed edits in IDLE.
//            Optional macro STEP_SEQ_PRESET_EN: reset and every stop reload
//            the PRESET pattern; otherwise reset clears and edits persist.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter int                                NUM_TRACKS = 5,
    parameter int                                NUM_STEPS  = 16,
    parameter logic [NUM_TRACKS*NUM_STEPS-1:0]   PRESET     = '0
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    step_sequencer_if.slave    bus
);
    localparam int              SW      = $clog2(NUM_STEPS);
    localparam logic [SW:0]     MAX_LEN = (SW+1)'(NUM_STEPS);

    typedef logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern_t;

`ifdef STEP_SEQ_PRESET_EN
    localparam pattern_t RESET_PATTERN = pattern_t'(PRESET);
`else
    // PRESET has no effect in this build; the pattern always starts empty.
    localparam pattern_t RESET_PATTERN = pattern_t'(PRESET) & pattern_t'(0);
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] step;
    logic [SW-1:0] step_next;
    logic          wrap;
    logic          wrap_next;
    pattern_t      pattern;
    pattern_t      pattern_next;
    logic [SW:0]   loop_len;
    logic          at_last;

    // Effective loop length: out-of-range requests fall back to the full pattern.
    always_comb begin
        loop_len = bus.LoopLen;
        if (bus.LoopLen == '0 || bus.LoopLen > MAX_LEN) begin
            loop_len = MAX_LEN;
        end
        // ">=" rather than "==" so a loop shortened under the pointer wraps at once.
        at_last = ({1'b0, step} >= (loop_len - (SW+1)'(1)));
    end

    // Next-state, step pointer, wrap pulse and pattern edit logic.
    always_comb begin
        state_next   = state;
        step_next    = step;
        wrap_next    = 1'b0;
        pattern_next = pattern;
        case (state)
            IDLE: begin
                for (int t = 0; t < NUM_TRACKS; t++) begin
                    if (bus.Toggle[t]) begin
                        pattern_next[t][bus.EditStep] = ~pattern[t][bus.EditStep];
                    end
                end
                if (bus.CCEN && bus.Start) begin
                    state_next = PLAY;
                    step_next  = '0;
                end
            end
            PLAY: begin
                if (bus.CCEN) begin
                    // Toggle lands on the step being left; heard next pass.
                    for (int t = 0; t < NUM_TRACKS; t++) begin
                        if (bus.Toggle[t]) begin
                            pattern_next[t][step] = ~pattern[t][step];
                        end
                    end
                    if (bus.Stop) begin
                        state_next = IDLE;
                        step_next  = '0;
`ifdef STEP_SEQ_PRESET_EN
                        pattern_next = RESET_PATTERN;
`endif
                    end else if (at_last) begin
                        step_next = '0;
                        wrap_next = 1'b1;
                    end else begin
                        step_next = step + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Clear overrides every other pattern update in the same cycle.
        if (bus.Clear) begin
            pattern_next = '0;
        end
    end

    // State, pointer, wrap and pattern registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            step    <= '0;
            wrap    <= 1'b0;
            pattern <= RESET_PATTERN;
        end else begin
            state   <= state_next;
            step    <= step_next;
            wrap    <= wrap_next;
            pattern <= pattern_next;
        end
    end

    assign bus.Step    = step;
    assign bus.Playing = (state == PLAY);
    assign bus.Wrap    = wrap;
    assign bus.Pattern = pattern;

    generate
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trig
            assign bus.TrigOut[t] = (state == PLAY) & pattern[t][step];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_step_sequencer
// Brief    : Directed bench for step_sequencer with a per-cycle scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_step_sequencer;
    localparam int NT = 5;
    localparam int NS = 16;
    localparam int SW = 4;
    localparam int W  = NT * NS;
    localparam logic [W-1:0] PRE = {5{16'h0101}};

`ifdef STEP_SEQ_PRESET_EN
    localparam logic [W-1:0] RST_PAT = PRE;
`else
    localparam logic [W-1:0] RST_PAT = '0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    step_sequencer_if #(.NUM_TRACKS(NT), .NUM_STEPS(NS)) bus ();

    step_sequencer #(
        .NUM_TRACKS (NT),
        .NUM_STEPS  (NS),
        .PRESET     (PRE)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [SW-1:0] step;
        logic          playing;
        logic [NT-1:0] trig;
        logic          wrap;
        logic [W-1:0]  pat;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int wraps = 0;

    // Reference model state
    logic          m_play;
    logic [SW-1:0] m_step;
    logic          m_wrap;
    logic [W-1:0]  m_pat;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_play = 1'b0;
        m_step = '0;
        m_wrap = 1'b0;
        m_pat  = RST_PAT;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        int           len;
        int           s;
        logic [W-1:0] p;
        len = (bus.LoopLen == 0 || bus.LoopLen > NS) ? NS : int'(bus.LoopLen);
        p = m_pat;
        m_wrap = 1'b0;
        if (!m_play) begin
            s = int'(bus.EditStep);
            for (int t = 0; t < NT; t++) if (bus.Toggle[t]) p[t*NS + s] = ~p[t*NS + s];
            if (bus.CCEN && bus.Start) begin
                m_play = 1'b1;
                m_step = '0;
            end
        end else if (bus.CCEN) begin
            s = int'(m_step);
            for (int t = 0; t < NT; t++) if (bus.Toggle[t]) p[t*NS + s] = ~p[t*NS + s];
            if (bus.Stop) begin
                m_play = 1'b0;
                m_step = '0;
`ifdef STEP_SEQ_PRESET_EN
                p = PRE;
`endif
            end else if (s >= len - 1) begin
                m_step = '0;
                m_wrap = 1'b1;
            end else begin
                m_step = m_step + 4'd1;
            end
        end
        if (bus.Clear) p = '0;
        m_pat = p;
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.step    = m_step;
        e.playing = m_play;
        e.wrap    = m_wrap;
        e.pat     = m_pat;
        for (int t = 0; t < NT; t++) e.trig[t] = m_play & m_pat[t*NS + int'(m_step)];
        return e;
    endfunction

    // One clock: drive, predict, clock, then compare outputs against the queue.
    task automatic cyc(input logic ccen, input logic start, input logic stop,
                       input logic clear, input logic [NT-1:0] tog);
        exp_t e;
        bus.CCEN   = ccen;
        bus.Start  = start;
        bus.Stop   = stop;
        bus.Clear  = clear;
        bus.Toggle = tog;
        model_edge();
        sb.push_back(make_exp());
        @(posedge Clk);
        #1;
        if (bus.Wrap) wraps++;
        e = sb.pop_front();
        chk("step",    W'(bus.Step),    W'(e.step));
        chk("playing", W'(bus.Playing), W'(e.playing));
        chk("trig",    W'(bus.TrigOut), W'(e.trig));
        chk("wrap",    W'(bus.Wrap),    W'(e.wrap));
        chk("pattern", bus.Pattern,     e.pat);
    endtask

    // One tempo tick followed by one quiet clock.
    task automatic tick(input logic [NT-1:0] tog);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, tog);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, fails=%0d", fails);
        $fatal(1, "timeout");
    end

    initial begin
        Reset        = 1'b1;
        bus.CCEN     = 1'b0;
        bus.Start    = 1'b0;
        bus.Stop     = 1'b0;
        bus.Clear    = 1'b0;
        bus.Toggle   = '0;
        bus.EditStep = '0;
        bus.LoopLen  = '0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("rst_pattern", bus.Pattern,      RST_PAT);
        chk("rst_step",    W'(bus.Step),     W'(0));
        chk("rst_playing", W'(bus.Playing),  W'(0));
        chk("rst_trig",    W'(bus.TrigOut),  W'(0));
        chk("rst_wrap",    W'(bus.Wrap),     W'(0));
        Reset = 1'b0;

        // Build track0 = 16'h0005 from an empty pattern with idle edits
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
        bus.EditStep = 4'd0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
        bus.EditStep = 4'd2;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
        chk("edit_track0", bus.Pattern, W'(16'h0005));

        // Full loop: start then 19 ticks -> 0..15,0..3
        bus.LoopLen = '0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("start_step", W'(bus.Step),       W'(0));
        chk("start_trig0", W'(bus.TrigOut[0]), W'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        wraps = 0;
        for (int i = 0; i < 19; i++) tick('0);
        chk("full_end_step", W'(bus.Step), W'(3));
        chk("full_wraps",    W'(wraps),    W'(1));

        // Short loop of 4, then shrink to 2 while at step 3
        bus.LoopLen = 5'd4;
        tick('0);
        chk("short_wrap_step", W'(bus.Step), W'(0));
        wraps = 0;
        for (int i = 0; i < 7; i++) tick('0);
        chk("short_step3",  W'(bus.Step), W'(3));
        chk("short_wraps",  W'(wraps),    W'(1));
        bus.LoopLen = 5'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("shrink_step", W'(bus.Step), W'(0));
        chk("shrink_wrap", W'(bus.Wrap), W'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        bus.LoopLen = 5'd17;

        // Live toggle at step 5; non-tick toggles are ignored
        for (int i = 0; i < 5; i++) tick('0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b11111);
        chk("live_bit_1_5", W'(bus.Pattern[1*NS + 5]), W'(1));
        for (int i = 0; i < 15; i++) tick('0);
        chk("pass2_step", W'(bus.Step),       W'(5));
        chk("pass2_trig1", W'(bus.TrigOut[1]), W'(1));

        // Stop with a toggle at step 7
        tick('0);
        tick('0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'b00100);
        chk("stop_playing", W'(bus.Playing), W'(0));
        chk("stop_trig",    W'(bus.TrigOut), W'(0));
`ifdef STEP_SEQ_PRESET_EN
        chk("stop_pattern", bus.Pattern, PRE);
`else
        chk("stop_bit_2_7", W'(bus.Pattern[2*NS + 7]), W'(1));
`endif

        // Idle edit without CCEN, then Clear beats Toggle
        bus.EditStep = 4'd9;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b10000);
        chk("idle_bit_4_9", W'(bus.Pattern[4*NS + 9]), W'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'b11111);
        chk("clear_all", bus.Pattern, W'(0));

        // Asynchronous reset in the middle of PLAY
        bus.EditStep = 4'd3;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b01000);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
        tick('0);
        tick('0);
        chk("pre_rst_playing", W'(bus.Playing), W'(1));
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_playing", W'(bus.Playing), W'(0));
        chk("arst_step",    W'(bus.Step),    W'(0));
        chk("arst_trig",    W'(bus.TrigOut), W'(0));
        chk("arst_pattern", bus.Pattern,     RST_PAT);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
